// File: rtl/pkt_fifo.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pkt_fifo : store-and-forward packet FIFO; words become readable on commit.
// Optional build macro PKT_FIFO_FWFT_EN selects first-word fall-through output.
// Revision: 1.0
// -----------------------------------------------------------------------------
module pkt_fifo #(
  parameter int pBITS  = 4,
  parameter int pWIDHT = 8,
  parameter int pAFULL = 2
) (
  input  logic              iclk,
  input  logic              ireset_n,
  input  logic              iwr,
  input  logic [pWIDHT-1:0] iw_data,
  input  logic              iw_last,
  input  logic              iw_drop,
  input  logic              ird,
  output logic [pWIDHT-1:0] or_data,
  output logic              or_last,
  output logic              oempty,
  output logic              ofull,
  output logic              oafull,
  output logic [pBITS:0]    opkt_cnt,
  output logic              odrop
);

  localparam int AW    = pBITS + 1;
  localparam int DEPTH = 2 ** pBITS;
  localparam logic [AW-1:0] DEPTH_C = AW'(DEPTH);
  localparam logic [AW-1:0] AFULL_C = AW'(pAFULL);

  logic [pWIDHT:0]   mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     wr_cmt_q, wr_cmt_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d;
  logic              drop_q, drop_d;
  logic [pWIDHT-1:0] rdata_q, rdata_d;
  logic              rlast_q, rlast_d;
  logic [pBITS:0]    pkt_cnt_q, pkt_cnt_d;

  logic [AW-1:0]     used_w;
  logic [AW-1:0]     free_w;
  logic              full_w;
  logic              mem_empty_w;
  logic [pWIDHT:0]   head_w;
  logic              mem_we_w;
  logic              commit_w;
  logic              rd_last_w;

  assign used_w      = wr_ptr_q - rd_ptr_q;
  assign free_w      = DEPTH_C - used_w;
  assign full_w      = (used_w == DEPTH_C);
  assign mem_empty_w = (rd_ptr_q == wr_cmt_q);
  assign head_w      = mem_q[rd_ptr_q[pBITS-1:0]];

  // Write side: tentative pointer advances per word, commit pointer per packet.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    wr_cmt_d = wr_cmt_q;
    ovf_d    = ovf_q;
    drop_d   = 1'b0;
    mem_we_w = 1'b0;
    commit_w = 1'b0;
    if (iw_drop) begin
      wr_ptr_d = wr_cmt_q;
      ovf_d    = 1'b0;
      drop_d   = 1'b1;
    end else if (iwr) begin
      if (ovf_q || full_w) begin
        if (iw_last) begin
          wr_ptr_d = wr_cmt_q;
          ovf_d    = 1'b0;
          drop_d   = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        mem_we_w = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (iw_last) begin
          wr_cmt_d = wr_ptr_q + AW'(1);
          commit_w = 1'b1;
        end
      end
    end
  end

`ifdef PKT_FIFO_FWFT_EN
  logic out_valid_q, out_valid_d;
  logic pop_w;
  logic load_w;

  assign pop_w  = ird && out_valid_q;
  assign load_w = !mem_empty_w && (!out_valid_q || pop_w);

  // Output register refills in the same edge it is popped when data exists.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    rdata_d     = rdata_q;
    rlast_d     = rlast_q;
    out_valid_d = out_valid_q;
    rd_last_w   = pop_w && rlast_q;
    if (load_w) begin
      rdata_d     = head_w[pWIDHT-1:0];
      rlast_d     = head_w[pWIDHT];
      rd_ptr_d    = rd_ptr_q + AW'(1);
      out_valid_d = 1'b1;
    end else if (pop_w) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) out_valid_q <= 1'b0;
    else           out_valid_q <= out_valid_d;
  end

  assign oempty = !out_valid_q;
`else
  logic rd_en_w;

  assign rd_en_w = ird && !mem_empty_w;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    rdata_d   = rdata_q;
    rlast_d   = rlast_q;
    rd_last_w = rd_en_w && head_w[pWIDHT];
    if (rd_en_w) begin
      rdata_d  = head_w[pWIDHT-1:0];
      rlast_d  = head_w[pWIDHT];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  assign oempty = mem_empty_w;
`endif

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    case ({commit_w, rd_last_w})
      2'b10:   pkt_cnt_d = pkt_cnt_q + (pBITS+1)'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - (pBITS+1)'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (mem_we_w) mem_q[wr_ptr_q[pBITS-1:0]] <= {iw_last, iw_data};
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      wr_ptr_q  <= '0;
      wr_cmt_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_q     <= 1'b0;
      drop_q    <= 1'b0;
      rdata_q   <= '0;
      rlast_q   <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      wr_cmt_q  <= wr_cmt_d;
      rd_ptr_q  <= rd_ptr_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
      rdata_q   <= rdata_d;
      rlast_q   <= rlast_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign or_data  = rdata_q;
  assign or_last  = rlast_q;
  assign ofull    = full_w;
  assign oafull   = (free_w <= AFULL_C);
  assign opkt_cnt = pkt_cnt_q;
  assign odrop    = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_pkt_fifo.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_pkt_fifo : directed self-checking bench for pkt_fifo (default parameters).
// Revision: 1.0
// -----------------------------------------------------------------------------
module tb_pkt_fifo;

  logic       iclk     = 1'b0;
  logic       ireset_n = 1'b0;
  logic       iwr      = 1'b0;
  logic [7:0] iw_data  = 8'h00;
  logic       iw_last  = 1'b0;
  logic       iw_drop  = 1'b0;
  logic       ird      = 1'b0;
  logic [7:0] or_data;
  logic       or_last;
  logic       oempty;
  logic       ofull;
  logic       oafull;
  logic [4:0] opkt_cnt;
  logic       odrop;

  int errors = 0;
  int checks = 0;

  pkt_fifo #(.pBITS(4), .pWIDHT(8), .pAFULL(2)) dut (
    .iclk     (iclk),
    .ireset_n (ireset_n),
    .iwr      (iwr),
    .iw_data  (iw_data),
    .iw_last  (iw_last),
    .iw_drop  (iw_drop),
    .ird      (ird),
    .or_data  (or_data),
    .or_last  (or_last),
    .oempty   (oempty),
    .ofull    (ofull),
    .oafull   (oafull),
    .opkt_cnt (opkt_cnt),
    .odrop    (odrop)
  );

  always #5 iclk = ~iclk;

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d, input logic l);
    iwr = 1'b1; iw_data = d; iw_last = l;
    step();
    iwr = 1'b0; iw_last = 1'b0;
  endtask

  // Extra edge the fall-through register needs before a committed word shows.
  task automatic settle();
`ifdef PKT_FIFO_FWFT_EN
    chk("fwft_empty_before_prefetch", oempty, 1);
    step();
`endif
  endtask

  // Pops one word; other inputs are left as the caller set them.
  task automatic rd_word(input logic [7:0] d, input logic l, input string tag);
`ifdef PKT_FIFO_FWFT_EN
    chk({tag, "_data"}, or_data, d);
    chk({tag, "_last"}, or_last, l);
    ird = 1'b1;
    step();
    ird = 1'b0;
`else
    ird = 1'b1;
    step();
    ird = 1'b0;
    chk({tag, "_data"}, or_data, d);
    chk({tag, "_last"}, or_last, l);
`endif
  endtask

  initial begin
    // Reset values while held in reset
    #12;
    chk("rst_empty", oempty, 1);
    chk("rst_full", ofull, 0);
    chk("rst_afull", oafull, 0);
    chk("rst_pktcnt", opkt_cnt, 0);
    chk("rst_drop", odrop, 0);
    chk("rst_data", or_data, 0);
    chk("rst_last", or_last, 0);
    ireset_n = 1'b1;
    step();

    // Three-word packet becomes visible only on the last word
    wr(8'h11, 0); chk("t1_empty_w1", oempty, 1);
    wr(8'h22, 0); chk("t1_empty_w2", oempty, 1);
    wr(8'h33, 1); chk("t1_pkt_commit", opkt_cnt, 1);
    settle();
    chk("t1_empty_commit", oempty, 0);
    rd_word(8'h11, 0, "t1_rd0");
    rd_word(8'h22, 0, "t1_rd1");
    rd_word(8'h33, 1, "t1_rd2");
    chk("t1_pkt_after", opkt_cnt, 0);
    chk("t1_empty_after", oempty, 1);
    ird = 1'b1; step(); ird = 1'b0;
    chk("t1_rd_empty_data", or_data, 8'h33);
    chk("t1_rd_empty_last", or_last, 1);
    chk("t1_rd_empty_pkt", opkt_cnt, 0);

    // Fill without last, then overflow on a last word drops the packet
    for (int k = 1; k <= 16; k++) begin
      wr(8'(8'h40 + k), 0);
      if (k == 13) chk("t2_afull_13", oafull, 0);
      if (k == 14) chk("t2_afull_14", oafull, 1);
      if (k == 15) chk("t2_full_15", ofull, 0);
    end
    chk("t2_full_16", ofull, 1);
    chk("t2_empty_16", oempty, 1);
    wr(8'h99, 1);
    chk("t2_drop_pulse", odrop, 1);
    chk("t2_full_after", ofull, 0);
    chk("t2_afull_after", oafull, 0);
    chk("t2_empty_after", oempty, 1);
    chk("t2_pkt_after", opkt_cnt, 0);
    step();
    chk("t2_drop_end", odrop, 0);

    // Explicit drop wins over a same-cycle write
    wr(8'hA1, 0);
    wr(8'hA2, 0);
    iw_drop = 1'b1;
    wr(8'hA3, 1);
    iw_drop = 1'b0;
    chk("t3_drop_pulse", odrop, 1);
    chk("t3_empty", oempty, 1);
    chk("t3_pkt", opkt_cnt, 0);
    wr(8'hB1, 1);
    chk("t3_drop_clear", odrop, 0);
    settle();
    chk("t3_b1_visible", oempty, 0);
    rd_word(8'hB1, 1, "t3_b1");
    chk("t3_empty_after", oempty, 1);

    // Reader sees only committed P1 while P2 is being written
    wr(8'hC1, 0);
    wr(8'hC2, 1);
    chk("t4_pkt_p1", opkt_cnt, 1);
    settle();
    iwr = 1'b1; iw_data = 8'hD1; iw_last = 1'b0;
    rd_word(8'hC1, 0, "t4_c1");
    iwr = 1'b0;
    chk("t4_pkt_mid", opkt_cnt, 1);
    rd_word(8'hC2, 1, "t4_c2");
    chk("t4_pkt_p1_read", opkt_cnt, 0);
    chk("t4_p2_hidden", oempty, 1);
    wr(8'hD2, 1);
    chk("t4_pkt_p2", opkt_cnt, 1);
    settle();
    chk("t4_p2_visible", oempty, 0);
    rd_word(8'hD1, 0, "t4_d1");
    rd_word(8'hD2, 1, "t4_d2");
    chk("t4_pkt_end", opkt_cnt, 0);

    // Asynchronous reset mid-packet and mid-read
    wr(8'hE1, 0);
    wr(8'hE2, 1);
    wr(8'hF1, 0);
    rd_word(8'hE1, 0, "t5_e1");
    #3 ireset_n = 1'b0;
    #1;
    chk("t5_async_empty", oempty, 1);
    chk("t5_async_data", or_data, 0);
    chk("t5_async_pkt", opkt_cnt, 0);
    chk("t5_async_afull", oafull, 0);
    #2 ireset_n = 1'b1;
    step();
    wr(8'h5A, 1);
    chk("t5_pkt_5a", opkt_cnt, 1);
    settle();
    rd_word(8'h5A, 1, "t5_5a");
    chk("t5_empty_end", oempty, 1);

`ifdef PKT_FIFO_FWFT_EN
    // Fall-through: committed word shows two edges after commit without ird
    wr(8'h77, 1);
    chk("t6_empty_commit", oempty, 1);
    step();
    chk("t6_empty_prefetch", oempty, 0);
    chk("t6_data_prefetch", or_data, 8'h77);
    ird = 1'b1; step(); ird = 1'b0;
    chk("t6_empty_pop", oempty, 1);
    chk("t6_pkt_pop", opkt_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
